// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_ctrl_pkg : shared types and constants for the PWM output controller.
// Rev 1.0
// ---------------------------------------------------------------------------
package pwm_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam logic [7:0] PWM_CNT_MAX = 8'd254;

    typedef struct packed {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
    } pwm_cfg_t;

endpackage
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_tick_gen : CLK_DIV prescaler, one-cycle tick, synchronous clear.
// Rev 1.0
// ---------------------------------------------------------------------------
module pwm_tick_gen #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q;
    logic [7:0] div_d;

    always_comb begin
        div_d = div_q + 8'd1;
        if (clr_i || (div_q == DIV_LAST)) begin
            div_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 8'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = ~clr_i & (div_q == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_output_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_output_controller : double-buffered PWM engine driving 16 output pins.
// Rev 1.0
// ---------------------------------------------------------------------------
module pwm_output_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    input  logic        cfg_update,
    output logic [15:0] pwm_out,
    output logic        cfg_pending,
    output logic        period_start
);

    pwm_cfg_t   live_w;
    pwm_cfg_t   staging_q;
    pwm_cfg_t   active_q;
    pwm_cfg_t   active_d;
    pwm_state_t state_q;
    logic [7:0] cnt_q;
    logic       pending_q;
    logic       start_q;
    logic [15:0] pwm_out_q;
    logic       period_start_q;

    logic        tick_w;
    logic        boundary_w;
    logic        commit_w;
    logic        run_d;
    logic        level_w;
    logic [15:0] pwm_out_d;

    assign live_w = {en_reg_out_15_8, en_reg_out_7_0,
                     en_reg_pwm_15_8, en_reg_pwm_7_0, pwm_duty_cycle};

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick_w)
    );

    assign boundary_w = (state_q == RUN) & tick_w & (cnt_q == PWM_CNT_MAX);

    // A boundary with nothing staged and no strobe leaves active untouched.
    assign commit_w = ((state_q == IDLE) & pending_q)
                    | (boundary_w & (pending_q | cfg_update));

    assign active_d  = commit_w ? (cfg_update ? live_w : staging_q) : active_q;
    assign run_d     = |(active_d.en_out & active_d.en_pwm);
    assign level_w   = (cnt_q < active_q.duty);
    assign pwm_out_d = active_q.en_out & (~active_q.en_pwm | {16{level_w}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q      <= '0;
            active_q       <= '0;
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            pending_q      <= 1'b0;
            start_q        <= 1'b0;
            pwm_out_q      <= 16'd0;
            period_start_q <= 1'b0;
        end else begin
            active_q <= active_d;
            if (cfg_update) begin
                staging_q <= live_w;
            end
            if (commit_w) begin
                pending_q <= 1'b0;
            end else if (cfg_update) begin
                pending_q <= 1'b1;
            end

            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (commit_w && run_d) begin
                        state_q <= RUN;
                        start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick_w) begin
                        if (cnt_q == PWM_CNT_MAX) begin
                            cnt_q <= 8'd0;
                            if (run_d) begin
                                start_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase

            // start_q marks the edge where cnt became 0; delaying it one
            // clock lines it up with the first registered output of the period.
            pwm_out_q      <= pwm_out_d;
            period_start_q <= start_q;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign cfg_pending  = pending_q;
    assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_output_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_output_controller : directed bench with a period-position model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pwm_output_controller;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 255 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] eo = 16'd0;
    logic [15:0] ep = 16'd0;
    logic [7:0]  duty = 8'd0;
    logic        cfg_update = 1'b0;
    logic [15:0] pwm_out;
    logic        cfg_pending;
    logic        period_start;

    int n_cmp = 0;
    int n_err = 0;

    pwm_output_controller #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo[7:0]),
        .en_reg_out_15_8 (eo[15:8]),
        .en_reg_pwm_7_0  (ep[7:0]),
        .en_reg_pwm_15_8 (ep[15:8]),
        .pwm_duty_cycle  (duty),
        .cfg_update      (cfg_update),
        .pwm_out         (pwm_out),
        .cfg_pending     (cfg_pending),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: position in the period is tracked as clocks since period start.
    logic [15:0] m_act_eo = 0, m_act_ep = 0, m_stg_eo = 0, m_stg_ep = 0;
    logic [7:0]  m_act_du = 0, m_stg_du = 0;
    logic        m_pend = 0, m_run = 0;
    int          m_t = 0;
    logic [15:0] exp_pwm = 0;
    logic        exp_pend = 0, exp_ps = 0;

    always @(posedge clk or negedge rst_n) begin
        logic        bnd, cmt, runc;
        logic [15:0] n_eo, n_ep;
        logic [7:0]  n_du;
        int          pos;
        if (!rst_n) begin
            m_act_eo = 0; m_act_ep = 0; m_act_du = 0;
            m_stg_eo = 0; m_stg_ep = 0; m_stg_du = 0;
            m_pend = 0; m_run = 0; m_t = 0;
            exp_pwm = 0; exp_pend = 0; exp_ps = 0;
        end else begin
            pos     = m_run ? (m_t / CLK_DIV) : 0;
            exp_pwm = m_act_eo & (~m_act_ep | {16{pos < int'(m_act_du)}});
            exp_ps  = m_run && (m_t == 0);
            bnd     = m_run && (m_t == PERIOD - 1);
            cmt     = (!m_run && m_pend) || (bnd && (m_pend || cfg_update));
            n_eo = cfg_update ? eo : m_stg_eo;
            n_ep = cfg_update ? ep : m_stg_ep;
            n_du = cfg_update ? duty : m_stg_du;
            if (cfg_update) begin
                m_stg_eo = eo; m_stg_ep = ep; m_stg_du = duty;
            end
            if (cmt) begin
                m_act_eo = n_eo; m_act_ep = n_ep; m_act_du = n_du; m_pend = 0;
            end else if (cfg_update) begin
                m_pend = 1;
            end
            runc = |(m_act_eo & m_act_ep);
            if (!m_run) begin
                if (cmt && runc) begin
                    m_run = 1; m_t = 0;
                end
            end else if (bnd) begin
                m_t = 0;
                if (!runc) m_run = 0;
            end else begin
                m_t++;
            end
            exp_pend = m_pend;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("pwm_out", pwm_out, exp_pwm);
        chk("cfg_pending", {15'd0, cfg_pending}, {15'd0, exp_pend});
        chk("period_start", {15'd0, period_start}, {15'd0, exp_ps});
    end

    task automatic apply_cfg(input logic [15:0] o, input logic [15:0] p, input logic [7:0] d);
        @(negedge clk);
        eo = o; ep = p; duty = d; cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
    endtask

    task automatic wait_ps();
        int k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (period_start !== 1'b1 && k < 2 * PERIOD + 10);
        if (period_start !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL wait_ps timeout: got no period_start expected a pulse");
        end
    endtask

    task automatic count_run(input logic v, output int n);
        n = 0;
        while (pwm_out[0] === v && n < 4000) begin
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic count_ps(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (period_start === 1'b1) n++;
        end
    endtask

    initial begin
        #(950_000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset pwm_out", pwm_out, 16'h0000);
        chk("reset pending", {15'd0, cfg_pending}, 16'd0);
        count_ps(50, n);
        chk("idle no period_start", n[15:0], 16'd0);
        chk("idle pwm_out", pwm_out, 16'h0000);

        // Static enable: visible two clocks after the strobe edge
        apply_cfg(16'hA5A5, 16'h0000, 8'd77);
        @(posedge clk); #1;
        chk("static lat1", pwm_out, 16'h0000);
        @(posedge clk); #1;
        chk("static lat2", pwm_out, 16'hA5A5);
        count_ps(300, n);
        chk("static no period_start", n[15:0], 16'd0);

        // Duty 64
        apply_cfg(16'h0001, 16'h0001, 8'd64);
        wait_ps();
        count_run(1'b1, n);
        chk("duty64 high", n[15:0], 16'd832);
        count_run(1'b0, n);
        chk("duty64 low", n[15:0], 16'd2483);
        chk("period edge ps", {15'd0, period_start}, 16'd1);

        // Duty 0
        apply_cfg(16'h0001, 16'h0001, 8'd0);
        wait_ps();
        n = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out[0] !== 1'b0) n++;
            @(posedge clk); #1;
        end
        chk("duty0 ones", n[15:0], 16'd0);

        // Duty 255 across 3 periods
        apply_cfg(16'h0001, 16'h0001, 8'd255);
        wait_ps();
        n = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (pwm_out[0] !== 1'b1) n++;
            @(posedge clk); #1;
        end
        chk("duty255 zeros", n[15:0], 16'd0);

        // Glitch-free mid-period update 64 -> 200
        apply_cfg(16'h0001, 16'h0001, 8'd64);
        wait_ps();
        fork
            begin
                repeat (400) @(negedge clk);
                apply_cfg(16'h0001, 16'h0001, 8'd200);
            end
        join_none
        count_run(1'b1, n);
        chk("glitch cur high", n[15:0], 16'd832);
        chk("glitch pending", {15'd0, cfg_pending}, 16'd1);
        wait_ps();
        chk("glitch pending clr", {15'd0, cfg_pending}, 16'd0);
        count_run(1'b1, n);
        chk("glitch next high", n[15:0], 16'd2600);

        // Two updates in one period: only the second lands
        apply_cfg(16'h0001, 16'h0001, 8'd10);
        repeat (100) @(negedge clk);
        apply_cfg(16'h0001, 16'h0001, 8'd100);
        chk("double pending", {15'd0, cfg_pending}, 16'd1);
        wait_ps();
        count_run(1'b1, n);
        chk("double high", n[15:0], 16'd1300);

        // Strobe on the boundary clock turning PWM off
        wait_ps();
        repeat (PERIOD - 2) @(negedge clk);
        apply_cfg(16'h00F1, 16'h0000, 8'd100);
        chk("simul pending", {15'd0, cfg_pending}, 16'd0);
        @(posedge clk); #1;
        chk("simul pwm_out", pwm_out, 16'h00F1);
        count_ps(600, n);
        chk("simul no period_start", n[15:0], 16'd0);
        chk("simul pwm hold", pwm_out, 16'h00F1);

        // Asynchronous reset in the middle of a RUN period
        apply_cfg(16'h0001, 16'h0001, 8'd128);
        wait_ps();
        repeat (500) @(posedge clk);
        apply_cfg(16'h0003, 16'h0003, 8'd50);
        chk("prereset high", {15'd0, pwm_out[0]}, 16'd1);
        chk("prereset pending", {15'd0, cfg_pending}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst pwm_out", pwm_out, 16'h0000);
        chk("async rst pending", {15'd0, cfg_pending}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_ps(200, n);
        chk("post rst no period_start", n[15:0], 16'd0);
        chk("post rst pwm_out", pwm_out, 16'h0000);
        chk("post rst pending", {15'd0, cfg_pending}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
